ram_cipher_io: RTL
==================

Name: ram_cipher_io

Overview:
Sits between the D-line driver's two data RAMs and the 64-bit GOST cipher core.
After a block is received, it reads the 1024 nibbles from the receive RAM and packs them into 64-bit words. It hands each word to the cipher over a valid/ready handshake and unpacks each cipher result into the send RAM.
A single-cycle done pulse tells the top-level FSM that the send RAM is ready for transmission.

Parameters:
ADDR_W, 10, RAM address width; a block is 2^ADDR_W nibbles (1024 = one 512-byte SD block)
WORD_W, 64, cipher word width; must be a multiple of 4; NIB = WORD_W/4 nibbles per word (16)

Ports:
iclk  input  1  SD clock domain clock; all logic on its rising edge
irst  input  1  synchronous, active-high reset
istart  input  1  one-cycle pulse; start processing one block; ignored unless in IDLE
oraddr  output  ADDR_W  receive-RAM read address
irdata  input  4  receive-RAM read data; valid one cycle after oraddr is presented
owaddr  output  ADDR_W  send-RAM write address
owdata  output  4  send-RAM write data
owrite_en  output  1  send-RAM write strobe
oword  output  WORD_W  word to cipher
oword_valid  output  1  oword is valid
iword_ready  input  1  cipher accepts oword when valid && ready
iresult  input  WORD_W  cipher result
iresult_valid  input  1  one-cycle pulse; iresult valid
obusy  output  1  high in every state except IDLE
odone  output  1  one-cycle pulse when the whole block is written

Behaviour:
- Reset (synchronous, irst=1 at a clock edge) puts the block in IDLE and sets all outputs to 0: oraddr, owaddr, owdata, owrite_en, oword, oword_valid, obusy, odone.
- The word counter wcnt (ADDR_W-log2(NIB) bits) and the nibble counter ncnt (log2(NIB)+1 bits) also reset to 0.
- Reset during any state aborts the block; no further RAM writes occur and no done pulse is produced.
- States: IDLE, READ, OFFER, WAIT_RES, WRITE, DONE.
- IDLE:
  - On istart, go to READ with wcnt=0 and ncnt=0.
  - istart in any other state is ignored.
- READ (NIB+1 cycles):
  - In cycle k (k = 0..NIB-1), oraddr = wcnt*NIB + k.
  - In cycles 1..NIB, shift the captured data in: sreg <= {sreg[WORD_W-5:0], irdata}.
  - The first nibble read therefore lands in oword[WORD_W-1:WORD_W-4] (MSB first, matching SD line order).
  - After cycle NIB, go to OFFER.
- OFFER:
  - oword = sreg and oword_valid = 1.
  - Both stay stable until the cycle where iword_ready = 1; on that edge, drop oword_valid and go to WAIT_RES.
  - If iword_ready is already high on the first OFFER cycle, the transfer completes in that one cycle.
- WAIT_RES:
  - On iresult_valid, latch iresult into the result register and go to WRITE.
  - iresult_valid in any other state is ignored.
  - There is no timeout; the block waits indefinitely.
- WRITE (NIB cycles):
  - In cycle k: owrite_en = 1, owaddr = wcnt*NIB + k, owdata = result[WORD_W-1-4k -: 4] (MSB nibble first).
  - Writes to the same addresses as the source nibbles.
  - After the last write: if wcnt == 2^ADDR_W/NIB - 1 (63), go to DONE; otherwise increment wcnt and go to READ.
- DONE: odone = 1 for exactly one cycle, then go to IDLE.
- obusy = (state != IDLE).
- owrite_en is 0 outside WRITE, and owdata/owaddr hold their last values.
- oraddr holds its last value outside READ.
- Address arithmetic is modulo 2^ADDR_W; the address after 1023 is never generated.
- Per-word latency = NIB+1 (read) + ≥1 (offer) + cipher latency + 1 + NIB (write) cycles.
- Timing with an always-ready cipher and a result one cycle after acceptance:
  - Per word: 17 + 1 + 1 + 16 = 35 cycles.
  - Whole block: 64×35 + 1 (DONE) cycles.

Test Plan:
- Identity cipher (result = accepted word, next cycle), receive RAM preloaded with addr[3:0]: one istart -> send RAM equals receive RAM; first oword = 64'h0123456789ABCDEF; odone pulses once, 64×35+1 cycles after istart.
- XOR cipher (result = word ^ 64'hFFFF_FFFF_FFFF_FFFF), random RAM content -> every send-RAM nibble equals ~(receive nibble); exactly 1024 owrite_en cycles.
- Backpressure: iword_ready low for 5 cycles in OFFER of word 3 -> oword_valid stays high and oword is unchanged for all 5 cycles; a single acceptance; the final RAM content is still correct.
- istart pulsed during READ of word 10 and iresult_valid pulsed during OFFER -> no restart, no spurious write; output is identical to the first scenario.
- irst asserted in WRITE of word 20 at nibble 7 -> next cycle all outputs are 0, in IDLE, no further owrite_en; a new istart then processes the full block correctly from word 0.
- Slow cipher (result 40 cycles after acceptance) -> obusy stays high throughout; odone arrives after 64×(34+40)+1 cycles.

Source files
------------

// File: rtl/ram_cipher_io.sv
`default_nettype none
// ============================================================================
// Module      : ram_cipher_io
// Description : Reads one block of nibbles from the receive RAM and packs them
//               MSB-first into cipher words. Each word is offered to the cipher
//               over a valid/ready handshake. Each result is unpacked back into
//               the send RAM at the source addresses. A one-cycle done pulse
//               marks the end of the block.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_cipher_io #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 64
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              istart,
    output logic [ADDR_W-1:0] oraddr,
    input  logic [3:0]        irdata,
    output logic [ADDR_W-1:0] owaddr,
    output logic [3:0]        owdata,
    output logic              owrite_en,
    output logic [WORD_W-1:0] oword,
    output logic              oword_valid,
    input  logic              iword_ready,
    input  logic [WORD_W-1:0] iresult,
    input  logic              iresult_valid,
    output logic              obusy,
    output logic              odone
);

    localparam int c_NIB    = WORD_W / 4;
    localparam int c_NIB_W  = $clog2(c_NIB);
    localparam int c_WCNT_W = ADDR_W - c_NIB_W;

    // READ runs nibble counts 0..NIB, WRITE runs 0..NIB-1
    localparam logic [c_NIB_W:0]    c_RD_LAST   = (c_NIB_W + 1)'(c_NIB);
    localparam logic [c_NIB_W:0]    c_WR_LAST   = (c_NIB_W + 1)'(c_NIB - 1);
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_OFFER    = 3'd2,
        S_WAIT_RES = 3'd3,
        S_WRITE    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t              r_state;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic [c_NIB_W:0]    r_ncnt;
    logic [WORD_W-1:0]   r_sreg;
    logic [WORD_W-1:0]   r_result;
    logic [WORD_W-1:0]   r_oword;
    logic [ADDR_W-1:0]   r_oraddr;
    logic [ADDR_W-1:0]   r_owaddr;
    logic [3:0]          r_owdata;
    logic                r_owrite_en;
    logic                r_oword_valid;
    logic                r_obusy;
    logic                r_odone;

    logic [c_WCNT_W-1:0] w_wcnt_inc;
    logic [WORD_W-1:0]   w_sreg_shift;

    assign w_wcnt_inc   = r_wcnt + c_WCNT_W'(1);
    // RAM data arrives one cycle after its address, so it is shifted in LSB-side
    assign w_sreg_shift = {r_sreg[WORD_W-5:0], irdata};

    // Block sequencer: every output is registered here
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state       <= S_IDLE;
            r_wcnt        <= '0;
            r_ncnt        <= '0;
            r_sreg        <= '0;
            r_result      <= '0;
            r_oword       <= '0;
            r_oraddr      <= '0;
            r_owaddr      <= '0;
            r_owdata      <= '0;
            r_owrite_en   <= 1'b0;
            r_oword_valid <= 1'b0;
            r_obusy       <= 1'b0;
            r_odone       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (istart) begin
                        r_wcnt   <= '0;
                        r_ncnt   <= '0;
                        r_oraddr <= '0;
                        r_obusy  <= 1'b1;
                        r_state  <= S_READ;
                    end
                end
                S_READ: begin
                    if (r_ncnt != '0) begin
                        r_sreg <= w_sreg_shift;
                    end
                    // Address stops at the last nibble of the word; it never wraps
                    if (r_ncnt < c_WR_LAST) begin
                        r_oraddr <= r_oraddr + ADDR_W'(1);
                    end
                    if (r_ncnt == c_RD_LAST) begin
                        r_oword       <= w_sreg_shift;
                        r_oword_valid <= 1'b1;
                        r_state       <= S_OFFER;
                    end else begin
                        r_ncnt <= r_ncnt + (c_NIB_W + 1)'(1);
                    end
                end
                S_OFFER: begin
                    if (iword_ready) begin
                        r_oword_valid <= 1'b0;
                        r_state       <= S_WAIT_RES;
                    end
                end
                S_WAIT_RES: begin
                    // First nibble goes straight out; the rest is queued MSB-first
                    if (iresult_valid) begin
                        r_result    <= {iresult[WORD_W-5:0], 4'h0};
                        r_owdata    <= iresult[WORD_W-1 -: 4];
                        r_owaddr    <= {r_wcnt, {c_NIB_W{1'b0}}};
                        r_owrite_en <= 1'b1;
                        r_ncnt      <= '0;
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_ncnt == c_WR_LAST) begin
                        r_owrite_en <= 1'b0;
                        if (r_wcnt == c_WCNT_LAST) begin
                            r_odone <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_wcnt   <= w_wcnt_inc;
                            r_ncnt   <= '0;
                            r_oraddr <= {w_wcnt_inc, {c_NIB_W{1'b0}}};
                            r_state  <= S_READ;
                        end
                    end else begin
                        r_owaddr <= r_owaddr + ADDR_W'(1);
                        r_owdata <= r_result[WORD_W-1 -: 4];
                        r_result <= {r_result[WORD_W-5:0], 4'h0};
                        r_ncnt   <= r_ncnt + (c_NIB_W + 1)'(1);
                    end
                end
                S_DONE: begin
                    r_odone <= 1'b0;
                    r_obusy <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_owrite_en   <= 1'b0;
                    r_oword_valid <= 1'b0;
                    r_odone       <= 1'b0;
                    r_obusy       <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign oraddr      = r_oraddr;
    assign owaddr      = r_owaddr;
    assign owdata      = r_owdata;
    assign owrite_en   = r_owrite_en;
    assign oword       = r_oword;
    assign oword_valid = r_oword_valid;
    assign obusy       = r_obusy;
    assign odone       = r_odone;

endmodule
`default_nettype wire
